pdp8_tt_buf: RTL and testbench
==============================

Name: pdp8_tt_buf

Overview:
- Buffered PDP-8 console/teletype IOT interface: the next generation of the single-character console block.
- Sits between the CPU IOT bus and a byte-level UART core.
- Adds parametrised RX/TX FIFOs, configurable device codes, a software interrupt enable, overrun detection, and an edge-qualified IOT strobe so a multi-cycle F1 cannot double-pop or double-push.

Parameters:
- RX_DEV, 6'o03, keyboard device code.
- TX_DEV, 6'o04, printer device code.
- RX_AW, 4, log2 of RX FIFO depth (16 entries).
- TX_AW, 4, log2 of TX FIFO depth.
- IE_RESET, 1'b1, interrupt-enable value after reset.

Ports:
- clk  in  1  system clock (the only clock).
- reset  in  1  synchronous, active-high reset.
- iot  in  1  IOT instruction in progress.
- state  in  4  CPU major state; F1 = 4'b0001.
- mb  in  12  memory buffer; mb[0]=IOP1, mb[1]=IOP2, mb[2]=IOP4.
- io_select  in  6  device code field.
- io_data_in  in  12  AC from CPU.
- io_data_out  out  12  AC to CPU.
- io_selected  out  1  this block decodes io_select.
- io_skip  out  1  skip request.
- io_data_avail  out  1  tied 1.
- io_interrupt  out  1  interrupt request.
- rx_byte  in  8  received byte from UART.
- rx_strobe  in  1  one-cycle pulse: rx_byte valid.
- tx_byte  out  8  byte to UART.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  UART accepts tx_byte on valid&ready.
- rx_ovr  out  1  sticky: received byte dropped (RX FIFO full).
- tx_ovr  out  1  sticky: TLS dropped (TX FIFO full).

Behaviour:
- Decode is combinational whenever state==F1 && iot && io_select matches. Outside that window: io_selected=0, io_skip=0, io_data_out=io_data_in.
- Side effects occur only on the first clk of each F1&iot window: strobe = F1&iot & ~f1_d, where f1_d is a registered copy of F1&iot.
- Keyboard decode (RX_DEV):
  - io_selected=1.
  - mb[0] KSF: io_skip = rx_flag, where rx_flag = RX FIFO non-empty.
  - io_data_out = mb[2] ? {4'b0, rx_head} : 12'b0.
  - mb[1] KCC: on strobe, pop the head if non-empty; pop when empty is a no-op.
  - mb==3'b000: no-op (AC passes unchanged).
- Printer decode (TX_DEV):
  - io_selected=1; io_data_out=io_data_in.
  - mb[0] TSF: io_skip = tx_flag.
  - mb[1] TCF: on strobe, tx_flag<=0.
  - mb[2] TLS: on strobe, tx_flag<=0; push io_data_in[7:0] if TX FIFO not full, else drop and set tx_ovr.
  - mb==3'b101 (6xx5, TIE): on strobe, ie<=io_data_in[0]. This overrides the TSF/TLS meaning of that code. No skip, no push.
- tx_flag:
  - Set on a cycle where the UART accepts a byte (tx_valid&tx_ready) and no TCF/TLS strobe occurs that cycle.
  - TCF/TLS strobe wins over a simultaneous set.
  - Reset value 0.
- TX drain: tx_valid = TX FIFO non-empty; tx_byte = TX head (first-word fall-through). Pop on tx_valid&tx_ready.
- RX fill: rx_strobe pushes rx_byte. If full, the byte is dropped and rx_ovr<=1. A push and a pop in the same cycle are both honoured, including when full (count unchanged).
- io_interrupt = ie & (rx_flag | tx_flag), combinational from registers.
- Reset: FIFOs empty (pointers 0), tx_flag=0, ie=IE_RESET, rx_ovr=0, tx_ovr=0, f1_d=0. Hence tx_valid=0 and io_interrupt=0.
- Reset asserted mid-transfer discards FIFO contents. A byte presented with tx_valid during the reset cycle is not considered sent.
- Latency:
  - rx_strobe to KSF skip true: 1 clk.
  - TLS strobe to tx_valid: 1 clk.
- Pointers are AW+1 bits with wrap-bit full/empty detection. Count arithmetic is modulo 2^(AW+1).

Decomposition:
- Shared package pdp8_pkg: CPU state constants F0..F3, IOP bit indices, and default device codes 6'o03/6'o04.
- One sub-module pdp8_tt_fifo: synchronous 8-bit FIFO, parameter AW, first-word fall-through. Ports: clk, reset, push, din, pop, dout, empty, full. Instantiated twice.

Test Plan:
- Reset then idle: io_interrupt=0, tx_valid=0, rx_ovr=0; KSF with F1&iot on device 03 gives io_skip=0.
- rx_strobe with 8'o101, then KRB (mb=3'b110) on device 03: io_skip via KSF=1 beforehand, io_data_out=12'o0101, FIFO empty afterwards, io_interrupt falls.
- TLS 12'o0123, 12'o0124 with tx_ready=0: tx_valid=1, tx_byte=8'o123. Raise tx_ready for 2 clks: bytes 123 then 124 sent in order, tx_flag=1, TSF skips.
- Push 17 RX bytes with no reads (RX_AW=4): first 16 retained in order, 17th dropped, rx_ovr=1.
- Hold F1&iot for 3 clks with KCC: exactly one byte popped. Repeat with TLS: exactly one byte pushed.
- TIE with AC=0 then rx_strobe: io_interrupt=0 while KSF still skips. TIE with AC=1: io_interrupt=1 next clk.

Source files
------------

// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions: CPU major states, IOP bit positions, default device codes.
package pdp8_pkg;

  localparam int unsigned DATA_W  = 12;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned DEV_W   = 6;
  localparam int unsigned MB_W    = 12;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_F0 = 4'd0,
    ST_F1 = 4'd1,
    ST_F2 = 4'd2,
    ST_F3 = 4'd3
  } cpu_state_e;

  localparam int unsigned IOP1 = 0;
  localparam int unsigned IOP2 = 1;
  localparam int unsigned IOP4 = 2;

  localparam logic [DEV_W-1:0] DEV_KBD = 6'o03;
  localparam logic [DEV_W-1:0] DEV_TTY = 6'o04;

  // 6xx5 on the printer is repurposed as "set interrupt enable"
  localparam logic [2:0] MB_TIE = 3'b101;

endpackage

// File: rtl/pdp8_tt_buf_if.sv
// Console bus bundle: CPU IOT side plus byte-level UART side.
interface pdp8_tt_buf_if;
  import pdp8_pkg::*;

  logic                 iot;
  logic [STATE_W-1:0]   state;
  logic [MB_W-1:0]      mb;
  logic [DEV_W-1:0]     io_select;
  logic [DATA_W-1:0]    io_data_in;
  logic [DATA_W-1:0]    io_data_out;
  logic                 io_selected;
  logic                 io_skip;
  logic                 io_data_avail;
  logic                 io_interrupt;
  logic [BYTE_W-1:0]    rx_byte;
  logic                 rx_strobe;
  logic [BYTE_W-1:0]    tx_byte;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 rx_ovr;
  logic                 tx_ovr;

  modport master (
    output iot, state, mb, io_select, io_data_in, rx_byte, rx_strobe, tx_ready,
    input  io_data_out, io_selected, io_skip, io_data_avail, io_interrupt,
           tx_byte, tx_valid, rx_ovr, tx_ovr
  );

  modport slave (
    input  iot, state, mb, io_select, io_data_in, rx_byte, rx_strobe, tx_ready,
    output io_data_out, io_selected, io_skip, io_data_avail, io_interrupt,
           tx_byte, tx_valid, rx_ovr, tx_ovr
  );

endinterface

// File: rtl/pdp8_tt_fifo.sv
// Synchronous byte FIFO, first-word fall-through, wrap-bit full/empty detection.
module pdp8_tt_fifo
  import pdp8_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  output logic [BYTE_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned PW    = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              pop_en;
  logic              push_en;

  // A push into a full FIFO still lands when the head leaves in the same cycle
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/pdp8_tt_buf.sv
// Buffered PDP-8 console: IOT decode for keyboard/printer over RX/TX FIFOs to a UART core.
module pdp8_tt_buf
  import pdp8_pkg::*;
#(
  parameter logic [DEV_W-1:0] RX_DEV   = DEV_KBD,
  parameter logic [DEV_W-1:0] TX_DEV   = DEV_TTY,
  parameter int unsigned      RX_AW    = 4,
  parameter int unsigned      TX_AW    = 4,
  parameter logic             IE_RESET = 1'b1
) (
  input logic          clk,
  input logic          reset,
  pdp8_tt_buf_if.slave bus
);

  logic              f1_iot;
  logic              f1_d;
  logic              strobe;
  logic              kbd_sel;
  logic              tty_sel;
  logic [2:0]        iop;
  logic              is_tie;
  logic              kcc;
  logic              tty_clr;
  logic              tls;
  logic              tie;
  logic              tx_accept;
  logic              rx_flag;
  logic              tx_flag;
  logic              ie;
  logic              rx_ovr_q;
  logic              tx_ovr_q;
  logic [BYTE_W-1:0] rx_head;
  logic              rx_empty;
  logic              rx_full;
  logic              tx_empty;
  logic              tx_full;
  logic [MB_W-4:0]   unused_mb;

  assign unused_mb = bus.mb[MB_W-1:3];

  // Side effects fire only on the first cycle of an F1 IOT window
  assign f1_iot  = (bus.state == STATE_W'(ST_F1)) & bus.iot;
  assign strobe  = f1_iot & ~f1_d;
  assign kbd_sel = f1_iot & (bus.io_select == RX_DEV);
  assign tty_sel = f1_iot & (bus.io_select == TX_DEV);
  assign iop     = bus.mb[2:0];
  assign is_tie  = (iop == MB_TIE);

  assign kcc     = strobe & kbd_sel & iop[IOP2];
  assign tty_clr = strobe & tty_sel & ~is_tie & (iop[IOP2] | iop[IOP4]);
  assign tls     = strobe & tty_sel & ~is_tie & iop[IOP4];
  assign tie     = strobe & tty_sel & is_tie;

  assign tx_accept = bus.tx_valid & bus.tx_ready;
  assign rx_flag   = ~rx_empty;

  pdp8_tt_fifo #(.AW(RX_AW)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.rx_strobe),
    .din   (bus.rx_byte),
    .pop   (kcc),
    .dout  (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

  pdp8_tt_fifo #(.AW(TX_AW)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tls),
    .din   (bus.io_data_in[BYTE_W-1:0]),
    .pop   (tx_accept),
    .dout  (bus.tx_byte),
    .empty (tx_empty),
    .full  (tx_full)
  );

  // Status registers; a TCF/TLS strobe wins over a same-cycle transmit completion
  always_ff @(posedge clk) begin
    if (reset) begin
      f1_d     <= 1'b0;
      tx_flag  <= 1'b0;
      ie       <= IE_RESET;
      rx_ovr_q <= 1'b0;
      tx_ovr_q <= 1'b0;
    end else begin
      f1_d <= f1_iot;
      if (tty_clr) begin
        tx_flag <= 1'b0;
      end else if (tx_accept) begin
        tx_flag <= 1'b1;
      end
      if (tie) begin
        ie <= bus.io_data_in[0];
      end
      if (bus.rx_strobe & rx_full & ~kcc) begin
        rx_ovr_q <= 1'b1;
      end
      if (tls & tx_full & ~tx_accept) begin
        tx_ovr_q <= 1'b1;
      end
    end
  end

  // Combinational IOT response while the CPU sits in the F1 window
  always_comb begin
    bus.io_selected = 1'b0;
    bus.io_skip     = 1'b0;
    bus.io_data_out = bus.io_data_in;
    if (kbd_sel) begin
      bus.io_selected = 1'b1;
      bus.io_skip     = iop[IOP1] & rx_flag;
      if (iop != 3'b000) begin
        bus.io_data_out = iop[IOP4] ? DATA_W'(rx_head) : '0;
      end
    end else if (tty_sel) begin
      bus.io_selected = 1'b1;
      bus.io_skip     = iop[IOP1] & ~is_tie & tx_flag;
    end
  end

  assign bus.io_data_avail = 1'b1;
  assign bus.io_interrupt  = ie & (rx_flag | tx_flag);
  assign bus.tx_valid      = ~tx_empty;
  assign bus.rx_ovr        = rx_ovr_q;
  assign bus.tx_ovr        = tx_ovr_q;

endmodule

// File: tb/tb_pdp8_tt_buf.sv
// Scoreboard bench for pdp8_tt_buf: queue-based reference model, directed plan then random traffic.
module tb_pdp8_tt_buf;

  localparam int unsigned RX_DEPTH = 16;
  localparam int unsigned TX_DEPTH = 16;

  typedef struct {
    logic        sel;
    logic        skip;
    logic [11:0] dout;
    bit          dmask;
    logic        txv;
    logic [7:0]  txb;
    logic        irq;
    logic        rovr;
    logic        tovr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  pdp8_tt_buf_if bus();

  pdp8_tt_buf dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit rnd_mode = 1'b0;

  exp_t       exp_q[$];
  logic [7:0] tx_exp[$];

  // Reference state: plain queues and flags
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  bit m_txflag, m_ie, m_rovr, m_tovr, m_f1p;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Monitor: pops expectations and compares against what the DUT shows
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL exp_underflow at %0t: got empty queue expected entry", $time);
      end else begin
        e = exp_q.pop_front();
        chk("io_selected", 32'(bus.io_selected), 32'(e.sel));
        chk("io_skip", 32'(bus.io_skip), 32'(e.skip));
        if (!e.dmask) chk("io_data_out", 32'(bus.io_data_out), 32'(e.dout));
        chk("tx_valid", 32'(bus.tx_valid), 32'(e.txv));
        if (e.txv) chk("tx_byte", 32'(bus.tx_byte), 32'(e.txb));
        chk("io_interrupt", 32'(bus.io_interrupt), 32'(e.irq));
        chk("rx_ovr", 32'(bus.rx_ovr), 32'(e.rovr));
        chk("tx_ovr", 32'(bus.tx_ovr), 32'(e.tovr));
        chk("io_data_avail", 32'(bus.io_data_avail), 32'd1);
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (tx_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_stream at %0t: got byte %0o expected none", $time, bus.tx_byte);
        end else begin
          chk("tx_stream", 32'(bus.tx_byte), 32'(tx_exp.pop_front()));
        end
      end
    end
  end

  // One clock: publish expectations for current inputs, then advance the model
  task automatic tick();
    exp_t e;
    logic [2:0] m;
    bit f1, kbd, tty, strobe, accept, kcc, tie, tcl, tls;
    logic [7:0] d;
    if (rnd_mode) begin
      bus.rx_strobe = ($urandom_range(0, 3) == 0);
      bus.rx_byte   = 8'($urandom);
      bus.tx_ready  = 1'($urandom);
    end
    m   = bus.mb[2:0];
    f1  = (bus.state == 4'd1) && bus.iot;
    kbd = f1 && (bus.io_select == 6'o03);
    tty = f1 && (bus.io_select == 6'o04);
    e.sel = 1'b0; e.skip = 1'b0; e.dout = bus.io_data_in; e.dmask = 1'b0;
    if (kbd) begin
      e.sel  = 1'b1;
      e.skip = m[0] && (rxq.size() > 0);
      if (m != 3'b000) begin
        if (!m[2]) e.dout = 12'o0;
        else if (rxq.size() > 0) e.dout = {4'b0, rxq[0]};
        else e.dmask = 1'b1;
      end
    end else if (tty) begin
      e.sel  = 1'b1;
      e.skip = m[0] && (m != 3'b101) && m_txflag;
    end
    e.txv  = (txq.size() > 0);
    e.txb  = e.txv ? txq[0] : 8'h00;
    e.irq  = m_ie && ((rxq.size() > 0) || m_txflag);
    e.rovr = m_rovr;
    e.tovr = m_tovr;
    if (chk_en) exp_q.push_back(e);

    @(posedge clk);
    if (reset) begin
      rxq.delete(); txq.delete(); tx_exp.delete();
      m_txflag = 0; m_ie = 1; m_rovr = 0; m_tovr = 0; m_f1p = 0;
    end else begin
      strobe = f1 && !m_f1p;
      accept = (txq.size() > 0) && bus.tx_ready;
      kcc = strobe && kbd && m[1];
      tie = strobe && tty && (m == 3'b101);
      tcl = strobe && tty && (m != 3'b101) && (m[1] || m[2]);
      tls = tcl && m[2];
      if (kcc && rxq.size() > 0) d = rxq.pop_front();
      if (bus.rx_strobe) begin
        if (rxq.size() < RX_DEPTH) rxq.push_back(bus.rx_byte);
        else m_rovr = 1;
      end
      if (accept) d = txq.pop_front();
      if (tls) begin
        if (txq.size() < TX_DEPTH) begin
          txq.push_back(bus.io_data_in[7:0]);
          tx_exp.push_back(bus.io_data_in[7:0]);
        end else m_tovr = 1;
      end
      if (tcl) m_txflag = 0;
      else if (accept) m_txflag = 1;
      if (tie) m_ie = bus.io_data_in[0];
      m_f1p = f1;
    end
    #1;
  endtask

  task automatic iot_op(input logic [5:0] dev, input logic [2:0] m, input logic [11:0] ac, input int n);
    bus.state      = 4'd1;
    bus.iot        = 1'b1;
    bus.io_select  = dev;
    bus.mb         = {9'($urandom), m};
    bus.io_data_in = ac;
    repeat (n) tick();
    bus.iot   = 1'b0;
    bus.state = 4'd0;
    tick();
  endtask

  task automatic rx_push(input logic [7:0] b);
    bus.rx_byte   = b;
    bus.rx_strobe = 1'b1;
    tick();
    bus.rx_strobe = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.iot = 0; bus.state = 0; bus.mb = 0; bus.io_select = 0; bus.io_data_in = 0;
    bus.rx_byte = 0; bus.rx_strobe = 0; bus.tx_ready = 0;
    m_ie = 1;
    tick(); tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // Idle after reset, KSF on an empty keyboard
    iot_op(6'o03, 3'b001, 12'o7777, 1);

    // One received byte, KSF then KRB
    rx_push(8'o101);
    iot_op(6'o03, 3'b001, 12'o0, 1);
    iot_op(6'o03, 3'b110, 12'o0, 1);
    repeat (2) tick();

    // Two TLS with UART stalled, then drain two bytes
    bus.tx_ready = 0;
    iot_op(6'o04, 3'b100, 12'o0123, 1);
    iot_op(6'o04, 3'b100, 12'o0124, 1);
    tick();
    bus.tx_ready = 1;
    repeat (2) tick();
    bus.tx_ready = 0;
    iot_op(6'o04, 3'b001, 12'o0, 1);
    iot_op(6'o04, 3'b010, 12'o0, 1);

    // RX overflow: 17 bytes, then read all back
    for (int i = 0; i < 17; i++) rx_push(8'($urandom));
    for (int i = 0; i < 16; i++) iot_op(6'o03, 3'b110, 12'o0, 1);
    iot_op(6'o03, 3'b001, 12'o0, 1);

    // Held F1: single pop / single push
    rx_push(8'o11);
    rx_push(8'o22);
    iot_op(6'o03, 3'b010, 12'o0, 3);
    iot_op(6'o03, 3'b110, 12'o0, 1);
    iot_op(6'o04, 3'b100, 12'o0777, 3);
    tick();
    bus.tx_ready = 1;
    repeat (2) tick();
    bus.tx_ready = 0;

    // TX overflow then drain
    for (int i = 0; i < 17; i++) iot_op(6'o04, 3'b100, 12'($urandom), 1);
    bus.tx_ready = 1;
    repeat (18) tick();
    bus.tx_ready = 0;

    // Interrupt enable via 6xx5
    iot_op(6'o04, 3'b010, 12'o0, 1);
    iot_op(6'o04, 3'b101, 12'o0, 1);
    rx_push(8'o55);
    iot_op(6'o03, 3'b001, 12'o0, 1);
    iot_op(6'o04, 3'b101, 12'o1, 1);
    iot_op(6'o03, 3'b110, 12'o0, 1);

    // Reset in the middle of a transfer
    for (int i = 0; i < 3; i++) iot_op(6'o04, 3'b100, 12'($urandom), 1);
    rx_push(8'o66);
    bus.tx_ready = 1;
    reset = 1;
    tick();
    reset = 0;
    bus.tx_ready = 0;
    repeat (3) tick();

    // Randomized traffic
    rnd_mode = 1'b1;
    for (int it = 0; it < 2500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 35) begin
        tick();
      end else if (r < 40) begin
        bus.state = 4'd2; bus.iot = 1; bus.io_select = 6'o03; bus.mb = 12'($urandom);
        tick();
        bus.state = 4'd0; bus.iot = 0;
      end else if (r < 41) begin
        reset = 1; tick(); reset = 0;
      end else begin
        logic [5:0] dev;
        case ($urandom_range(0, 4))
          0, 1:    dev = 6'o03;
          2, 3:    dev = 6'o04;
          default: dev = 6'($urandom);
        endcase
        iot_op(dev, 3'($urandom), 12'($urandom), int'($urandom_range(1, 3)));
      end
    end
    rnd_mode = 1'b0;
    bus.rx_strobe = 0;
    bus.tx_ready = 1;
    repeat (20) tick();
    chk_en = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
